light_interval_timer: RTL and testbench

//  Seconds-resolution down-counter driven by traffic_light_controller (en/load/init in, out back).

---
 rtl/light_interval_timer.sv | 130 +++++++++++++
 tb/tb_light_interval_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/light_interval_timer.sv
// light_interval_timer
//   Seconds-resolution down-counter for the traffic-light controller. A prescaler divides clk
//   into 1 s ticks. Each tick decrements out. Terminal count is reported as a one-cycle done
//   pulse and as an expired level.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per 1 s tick (>= 2)
//   CNT_W          width of init/out in seconds
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   en       count enable; 0 pauses out and prescaler
//   load     load init into out; has priority over en
//   init     interval in seconds, sampled when load=1
//   out      seconds remaining
//   tick     1-cycle pulse on the edge where out decrements
//   done     1-cycle pulse on the edge where out counts 1->0
//   expired  high while in DONE
//   state    debug: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
module light_interval_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] init,
  output logic [CNT_W-1:0] out,
  output logic             tick,
  output logic             done,
  output logic             expired,
  output logic [1:0]       state
);

  localparam int unsigned    PreW   = $clog2(TICKS_PER_SEC);
  localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (load) begin
      // Load wins over any tick that would have landed on this edge.
      out_d = init;
      pre_d = '0;
      if (init == '0) begin
        state_d = StDone;
      end else if (en) begin
        state_d = StRun;
      end else begin
        state_d = StPause;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        // PAUSE with en=1 steps the prescaler on the resume edge, so the held
        // fraction of a second is not lost.
        StRun, StPause: begin
          if (!en) begin
            state_d = StPause;
          end else begin
            state_d = StRun;
            if (pre_q == PreMax) begin
              pre_d  = '0;
              out_d  = out_q - 1'b1;
              tick_d = 1'b1;
              if (out_q == CNT_W'(1)) begin
                done_d  = 1'b1;
                state_d = StDone;
              end
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
        end
        StDone: begin
          out_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end

    expired_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      out_q     <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign out     = out_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign expired = expired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_light_interval_timer.sv
module tb_light_interval_timer;

  localparam int unsigned TPS = 4;
  localparam int unsigned CW  = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          load;
  logic [CW-1:0] init;
  logic [CW-1:0] out;
  logic          tick;
  logic          done;
  logic          expired;
  logic [1:0]    state;

  int n_cmp;
  int n_err;

  light_interval_timer #(
    .TICKS_PER_SEC(TPS),
    .CNT_W        (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .init   (init),
    .out    (out),
    .tick   (tick),
    .done   (done),
    .expired(expired),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; init = '0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out !== 4'd0) begin n_err++; $display("FAIL reset_out: got %0d want 0", out); end
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if ({tick, done, expired} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {tick, done, expired});
    end
    @(negedge clk); rst = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({state, out} !== 6'b00_0000) begin
      n_err++; $display("FAIL idle_ignores_en: got state=%b out=%0d want 00/0", state, out);
    end
    en = 1'b0;
  endtask

  task automatic test_full_count();
    logic [CW-1:0] exp_out;
    @(negedge clk); load = 1'b1; init = 4'd15; en = 1'b1;
    @(negedge clk); load = 1'b0;
    n_cmp++; if (out !== 4'd15 || state !== 2'b01 || tick !== 1'b0) begin
      n_err++; $display("FAIL load15: got out=%0d state=%b tick=%b want 15/01/0", out, state, tick);
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      exp_out = 4'(15 - k / 4);
      n_cmp++; if (out !== exp_out || tick !== (k % 4 == 0) || done !== (k == 60)) begin
        n_err++;
        $display("FAIL count15 edge %0d: got out=%0d tick=%b done=%b want %0d/%b/%b",
                 k, out, tick, done, exp_out, (k % 4 == 0), (k == 60));
      end
    end
    n_cmp++; if (state !== 2'b11 || expired !== 1'b1) begin
      n_err++; $display("FAIL done15: got state=%b expired=%b want 11/1", state, expired);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++; if (out !== 4'd0 || state !== 2'b11 || {tick, done, expired} !== 3'b001) begin
        n_err++; $display("FAIL hold_done %0d: got out=%0d state=%b tdx=%b want 0/11/001",
                          k, out, state, {tick, done, expired});
      end
    end
  endtask

  task automatic test_pause_resume();
    @(negedge clk); load = 1'b1; init = 4'd11; en = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (6) @(negedge clk);  // out=10, prescaler=2
    n_cmp++; if (out !== 4'd10 || state !== 2'b01) begin
      n_err++; $display("FAIL pre_pause: got out=%0d state=%b want 10/01", out, state);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (out !== 4'd10 || state !== 2'b10 || tick !== 1'b0) begin
        n_err++; $display("FAIL paused %0d: got out=%0d state=%b tick=%b want 10/10/0",
                          k, out, state, tick);
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (out !== 4'd10 || state !== 2'b01 || tick !== 1'b0) begin
      n_err++; $display("FAIL resume1: got out=%0d state=%b tick=%b want 10/01/0", out, state, tick);
    end
    @(negedge clk);
    n_cmp++; if (out !== 4'd9 || tick !== 1'b1) begin
      n_err++; $display("FAIL resume2: got out=%0d tick=%b want 9/1", out, tick);
    end
  endtask

  task automatic test_en_fall_on_tick();
    @(negedge clk); load = 1'b1; init = 4'd2; en = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);  // prescaler at TPS-1
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (out !== 4'd2 || tick !== 1'b0 || state !== 2'b10) begin
      n_err++; $display("FAIL en_fall_tick: got out=%0d tick=%b state=%b want 2/0/10", out, tick, state);
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (out !== 4'd1 || tick !== 1'b1) begin
      n_err++; $display("FAIL en_rise_tick: got out=%0d tick=%b want 1/1", out, tick);
    end
  endtask

  task automatic test_zero_load();
    @(negedge clk); load = 1'b1; init = 4'd0; en = 1'b1;
    @(negedge clk); load = 1'b0;
    n_cmp++; if (state !== 2'b11 || expired !== 1'b1 || out !== 4'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL zero_load: got state=%b exp=%b out=%0d done=%b want 11/1/0/0",
                        state, expired, out, done);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || out !== 4'd0) begin
        n_err++; $display("FAIL zero_hold %0d: got done=%b out=%0d want 0/0", k, done, out);
      end
    end
  endtask

  task automatic test_load_on_terminal();
    @(negedge clk); load = 1'b1; init = 4'd1; en = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; init = 4'd7;
    @(negedge clk); load = 1'b0;
    n_cmp++; if (out !== 4'd7 || done !== 1'b0 || tick !== 1'b0 || state !== 2'b01) begin
      n_err++; $display("FAIL load_terminal: got out=%0d done=%b tick=%b state=%b want 7/0/0/01",
                        out, done, tick, state);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (out !== 4'd7 || tick !== 1'b0) begin
      n_err++; $display("FAIL presc_cleared_a: got out=%0d tick=%b want 7/0", out, tick);
    end
    @(negedge clk);
    n_cmp++; if (out !== 4'd6 || tick !== 1'b1) begin
      n_err++; $display("FAIL presc_cleared_b: got out=%0d tick=%b want 6/1", out, tick);
    end
  endtask

  task automatic test_reset_mid_count();
    @(negedge clk); load = 1'b1; init = 4'd8; en = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++; if (out !== 4'd5 || tick !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: got out=%0d tick=%b want 5/1", out, tick);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out !== 4'd0 || state !== 2'b00 || {tick, done, expired} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset: got out=%0d state=%b tdx=%b want 0/00/000",
                        out, state, {tick, done, expired});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); load = 1'b1; init = 4'd3; en = 1'b1;
    @(negedge clk); load = 1'b0;
    n_cmp++; if (out !== 4'd3 || state !== 2'b01) begin
      n_err++; $display("FAIL reload3: got out=%0d state=%b want 3/01", out, state);
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++; if (out !== 4'(3 - k / 4) || done !== (k == 12)) begin
        n_err++; $display("FAIL count3 edge %0d: got out=%0d done=%b want %0d/%b",
                          k, out, done, 3 - k / 4, (k == 12));
      end
    end
    n_cmp++; if (state !== 2'b11 || expired !== 1'b1) begin
      n_err++; $display("FAIL done3: got state=%b expired=%b want 11/1", state, expired);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_count();
    test_pause_resume();
    test_en_fall_on_tick();
    test_zero_load();
    test_load_on_terminal();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
